fp_mul_pipe: RTL



---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_mul_round.sv | 72 +++++++
 rtl/fp_mul_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
// Rounding mode is chosen by the FP_MUL_RNE_EN macro in fp_mul_round.
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
  } fp_flags_t;

  // Control payload shared by S1 and S2: the result sign and what kind of result it will be.
  typedef struct packed {
    logic      sign;
    fp_class_t kind;
  } fp_ctrl_t;

  localparam int FP_MAX_W = 64;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

  function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero);
    if (exp_zero) return FP_ZERO;
    if (exp_ones) return frac_zero ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// S3 of the multiplier: normalise the raw product, round, range-check and pack.
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  fp_ctrl_t                ctrl,
  input  logic signed [EXP_W+1:0] exp_sum,
  input  logic [2*MAN_W+1:0]      prod,
  output logic [EXP_W+MAN_W:0]    product,
  output fp_flags_t               flags
);

  localparam logic signed [EXP_W+1:0] EXP_MAX   = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO  = '0;
  localparam logic [FP_MAX_W-1:0]     QNAN_FULL = qnan_bits(EXP_W, MAN_W);
  localparam logic [EXP_W+MAN_W:0]    QNAN      = QNAN_FULL[EXP_W+MAN_W:0];

  logic [2*MAN_W+1:0]      norm;
  logic signed [EXP_W+1:0] exp_norm;
  logic signed [EXP_W+1:0] exp_rnd;
  logic [MAN_W:0]          frac_rnd;
  logic                    round_up;
  logic                    unused_bits;

  // After this shift the leading one always sits at the top bit of norm.
  assign norm     = prod[2*MAN_W+1] ? prod : {prod[2*MAN_W:0], 1'b0};
  assign exp_norm = exp_sum + $signed({{(EXP_W+1){1'b0}}, prod[2*MAN_W+1]});

`ifdef FP_MUL_RNE_EN
  logic guard;
  logic sticky;
  assign guard       = norm[MAN_W];
  assign sticky      = |norm[MAN_W-1:0];
  assign round_up    = guard & (sticky | norm[MAN_W+1]);
  assign unused_bits = norm[2*MAN_W+1];
`else
  assign round_up    = 1'b0;
  assign unused_bits = ^{norm[2*MAN_W+1], norm[MAN_W:0]};
`endif

  // A carry out of the fraction means it wrapped to zero; the exponent absorbs it.
  assign frac_rnd = {1'b0, norm[2*MAN_W:MAN_W+1]} + {{MAN_W{1'b0}}, round_up};
  assign exp_rnd  = exp_norm + $signed({{(EXP_W+1){1'b0}}, frac_rnd[MAN_W]});

  always_comb begin
    product = '0;
    flags   = '0;
    case (ctrl.kind)
      FP_NAN: begin
        product       = QNAN;
        flags.invalid = 1'b1;
      end
      FP_INF:  product = {ctrl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: product = {ctrl.sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (exp_rnd >= EXP_MAX) begin
          product        = {ctrl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags.overflow = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
          product         = {ctrl.sign, {(EXP_W+MAN_W){1'b0}}};
          flags.underflow = 1'b1;
        end else begin
          product = {ctrl.sign, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both sides.
// Define FP_MUL_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_product,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_invalid
);

  localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W+2)'(bias(EXP_W));

  typedef struct packed {
    fp_ctrl_t         ctrl;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W:0]   man_a;
    logic [MAN_W:0]   man_b;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    fp_ctrl_t           ctrl;
    logic [EXP_W+1:0]   exp_sum;
    logic [2*MAN_W+1:0] prod;
    logic [TAG_W-1:0]   tag;
  } s2_t;

  logic s1_valid, s2_valid, alive;
  logic s1_en, s2_en, s3_en, accept_in;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  fp_class_t cls_a, cls_b;
  logic [EXP_W+MAN_W:0] rnd_product;
  fp_flags_t            rnd_flags;

  // A stage may load when it is empty or its contents move on, so bubbles collapse.
  assign s3_en     = ~out_valid | out_ready;
  assign s2_en     = ~s2_valid | s3_en;
  assign s1_en     = ~s1_valid | s2_en;
  assign in_ready  = alive & s1_en;
  assign accept_in = in_valid & in_ready;

  always_comb begin
    cls_a = classify(in_a[EXP_W+MAN_W-1:MAN_W] == '0, &in_a[EXP_W+MAN_W-1:MAN_W],
                     in_a[MAN_W-1:0] == '0);
    cls_b = classify(in_b[EXP_W+MAN_W-1:MAN_W] == '0, &in_b[EXP_W+MAN_W-1:MAN_W],
                     in_b[MAN_W-1:0] == '0);
    s1_d           = '0;
    s1_d.ctrl.sign = in_a[EXP_W+MAN_W] ^ in_b[EXP_W+MAN_W];
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_ZERO && cls_b == FP_INF) || (cls_a == FP_INF && cls_b == FP_ZERO))
      s1_d.ctrl.kind = FP_NAN;
    else if (cls_a == FP_INF || cls_b == FP_INF)
      s1_d.ctrl.kind = FP_INF;
    else if (cls_a == FP_ZERO || cls_b == FP_ZERO)
      s1_d.ctrl.kind = FP_ZERO;
    else
      s1_d.ctrl.kind = FP_NORM;
    s1_d.exp_a = in_a[EXP_W+MAN_W-1:MAN_W];
    s1_d.exp_b = in_b[EXP_W+MAN_W-1:MAN_W];
    s1_d.man_a = {1'b1, in_a[MAN_W-1:0]};
    s1_d.man_b = {1'b1, in_b[MAN_W-1:0]};
    s1_d.tag   = in_tag;
  end

  always_comb begin
    s2_d         = '0;
    s2_d.ctrl    = s1_q.ctrl;
    s2_d.exp_sum = $signed({2'b00, s1_q.exp_a}) + $signed({2'b00, s1_q.exp_b}) - BIAS_E;
    s2_d.prod    = {{(MAN_W+1){1'b0}}, s1_q.man_a} * {{(MAN_W+1){1'b0}}, s1_q.man_b};
    s2_d.tag     = s1_q.tag;
  end

  fp_mul_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round (
    .ctrl    (s2_q.ctrl),
    .exp_sum ($signed(s2_q.exp_sum)),
    .prod    (s2_q.prod),
    .product (rnd_product),
    .flags   (rnd_flags)
  );

  // alive keeps in_ready low through reset and for the cycle in which rst is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      alive    <= 1'b0;
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      alive <= 1'b1;
      if (s1_en) begin
        s1_valid <= accept_in;
        if (accept_in) s1_q <= s1_d;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_product   <= '0;
      out_tag       <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_invalid   <= 1'b0;
    end else if (s3_en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_product   <= rnd_product;
        out_tag       <= s2_q.tag;
        out_overflow  <= rnd_flags.overflow;
        out_underflow <= rnd_flags.underflow;
        out_invalid   <= rnd_flags.invalid;
      end
    end
  end

endmodule
